// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states and
// EX operand-forwarding select encodings.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Youngest producer wins; $0 is never a forwarding source.
  function automatic logic [1:0] fwd_pick(
    input logic [4:0] src,
    input logic [4:0] mem_rd, input logic mem_we,
    input logic [4:0] wb_rd,  input logic wb_we
  );
    if (mem_we && mem_rd != 5'd0 && mem_rd == src)
      return FWD_EXMEM;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == src)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Mult/div occupancy timer: loadable down-counter with zero flag.
// Latency: count visible the cycle after load/dec; no backpressure (load/dec gate it).
// Backpressure: caller withholds dec while the pipeline is frozen.
module md_timer #(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = $clog2(MD_LATENCY);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= W'(MD_LATENCY - 2);
    else if (dec)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, EX forwarding, mult/div stall schedule.
// Latency: all outputs combinational from state and inputs; state registered.
// Backpressure: dmem_ready low freezes every stage. Macro PIPE_CTRL_FWD_EN enables forwarding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic       ex_muldiv,
  input  logic       ex_redirect,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_regwrite,
  input  logic       wb_regwrite,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_start,
  output logic       md_busy
);

  state_t state, state_nxt;
  logic   md_load, md_dec, md_zero;
  logic   hazard;
  logic   id_dep_ex, id_dep_mem, load_use;
  logic [1:0] fa, fb;

  md_timer #(.MD_LATENCY(MD_LATENCY)) u_md_timer (
    .clk  (clk),
    .rst  (rst),
    .load (md_load),
    .dec  (md_dec),
    .zero (md_zero)
  );

  assign id_dep_ex  = ex_rd != 5'd0 &&
                      ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
  assign id_dep_mem = mem_rd != 5'd0 &&
                      ((id_use_rs && mem_rd == id_rs) || (id_use_rt && mem_rd == id_rt));
  assign load_use   = ex_memread && id_dep_ex;

`ifdef PIPE_CTRL_FWD_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, ex_regwrite, mem_regwrite & id_dep_mem};
  assign hazard    = load_use;
  assign fa        = fwd_pick(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
  assign fb        = fwd_pick(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
`else
  // Without bypass paths every in-flight producer must drain to WB first.
  logic unused_ok;
  assign unused_ok = &{1'b0, ex_rs, ex_rt, wb_rd, wb_regwrite};
  assign hazard    = (ex_regwrite && id_dep_ex) || (mem_regwrite && id_dep_mem) || load_use;
  assign fa        = FWD_RF;
  assign fb        = FWD_RF;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    md_load     = 1'b0;
    md_dec      = 1'b0;
    md_start    = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = fa;
    fwd_b       = fb;
    md_busy     = (state == MD_BUSY);

    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush}         = '1;
      fwd_a   = FWD_RF;
      fwd_b   = FWD_RF;
      md_busy = 1'b0;
    end else if (!dmem_ready) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    end else if (state == RUN) begin
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (ex_muldiv) begin
        md_start    = 1'b1;
        md_load     = 1'b1;
        state_nxt   = MD_BUSY;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
      end else if (hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end else if (!md_zero) begin
      md_dec      = 1'b1;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else begin
      // Final occupancy cycle: the mult/div result advances into MEM.
      state_nxt = RUN;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios then random traffic
// against a cycle-count model of the pipeline schedule.
module tb_pipe_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_muldiv, ex_redirect;
  logic       mem_regwrite, wb_regwrite, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, md_start, md_busy;
  logic [1:0] fwd_a, fwd_b;

  int n_cmp = 0;
  int n_bad = 0;
  int md_left = 0;          // remaining EX cycles of the mult/div in flight
  int cnt_start, cnt_xflush, cnt_busy;
  logic last_idex_en;

  pipe_ctrl #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_muldiv(ex_muldiv), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
`ifdef PIPE_CTRL_FWD_EN
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return r != 0 && ((id_use_rs && id_rs == r) || (id_use_rt && id_rt == r));
  endfunction

  // Expected {pc,ifid,idex,exmem,memwb enables, ifid/idex/exmem flush, md_start, md_busy}
  function automatic logic [9:0] ref_ctl();
    bit stall;
    stall = ex_memread && reads(ex_rd);
`ifndef PIPE_CTRL_FWD_EN
    stall = stall || (ex_regwrite && reads(ex_rd)) || (mem_regwrite && reads(mem_rd));
`endif
    if (rst)                       return 10'b00000_111_0_0;
    if (!dmem_ready)               return {5'b00000, 3'b000, 1'b0, md_left > 0};
    if (md_left == 1)              return 10'b11111_000_0_1;
    if (md_left > 1)               return 10'b00011_001_0_1;
    if (ex_redirect)               return 10'b11111_110_0_0;
    if (ex_muldiv)                 return 10'b00011_001_1_0;
    if (stall)                     return 10'b00111_010_0_0;
    return 10'b11111_000_0_0;
  endfunction

  task automatic cycle(input string tag);
    logic [9:0] got;
    #1;
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, md_start, md_busy};
    check({tag, "_ctl"}, 32'(got), 32'(ref_ctl()));
    check({tag, "_fwda"}, 32'(fwd_a), 32'(rst ? 2'b00 : ref_fwd(ex_rs)));
    check({tag, "_fwdb"}, 32'(fwd_b), 32'(rst ? 2'b00 : ref_fwd(ex_rt)));
    cnt_start  += int'(md_start);
    cnt_xflush += int'(exmem_flush);
    cnt_busy   += int'(md_busy);
    last_idex_en = idex_en;
    @(posedge clk);
    if (rst) md_left = 0;
    else if (dmem_ready) begin
      if (md_left > 0) md_left--;
      else if (!ex_redirect && ex_muldiv) md_left = LAT - 1;
    end
    #1;
  endtask

  task automatic clear();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_muldiv, ex_redirect} = '0;
    {mem_regwrite, wb_regwrite} = '0;
    dmem_ready = 1'b1;
  endtask

  initial begin
    int occ;
    clear();
    rst = 1'b1;
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;
    cycle("post_rst");

    // lw $8 in EX, add $8 in ID; then it drains through MEM and WB
    ex_memread = 1; ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    cycle("lu_stall");
    clear(); mem_rd = 8; mem_regwrite = 1; id_rs = 8; id_use_rs = 1;
    cycle("lu_mem");
    clear(); wb_rd = 8; wb_regwrite = 1; ex_rs = 8;
    cycle("lu_fwd");

    clear(); mem_rd = 9; mem_regwrite = 1; wb_rd = 9; wb_regwrite = 1; ex_rs = 9; ex_rt = 9;
    cycle("fwd_dbl");
    mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
    cycle("fwd_r0");

    clear(); cnt_start = 0; cnt_xflush = 0; cnt_busy = 0;
    ex_muldiv = 1;
    for (int i = 0; i < LAT; i++) cycle("md");
    ex_muldiv = 0;
    cycle("md_after");
    check("md_start_cnt", 32'(cnt_start), 32'd1);
    check("md_xflush_cnt", 32'(cnt_xflush), 32'(LAT - 1));
    check("md_busy_cnt", 32'(cnt_busy), 32'(LAT - 1));

    clear(); ex_redirect = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    cycle("redir_lu");

    // mult/div with a 3-cycle data-memory wait inside its busy window
    clear(); cnt_start = 0; ex_muldiv = 1; occ = 0;
    for (int i = 0; i < 20; i++) begin
      dmem_ready = !(i >= 2 && i <= 4);
      cycle("md_wait");
      occ++;
      if (dmem_ready && last_idex_en) break;
    end
    check("md_occupancy", 32'(occ), 32'(LAT + 3));
    check("md_wait_start_cnt", 32'(cnt_start), 32'd1);
    clear();
    cycle("md_wait_done");

    for (int i = 0; i < 2000; i++) begin
      logic [3:0] regs[7];
      foreach (regs[k]) regs[k] = 4'($urandom_range(0, 3));
      id_rs = 5'(regs[0]); id_rt = 5'(regs[1]); ex_rs = 5'(regs[2]); ex_rt = 5'(regs[3]);
      ex_rd = 5'(regs[4]); mem_rd = 5'(regs[5]); wb_rd = 5'(regs[6]);
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      ex_memread = ($urandom_range(0, 3) == 0);
      ex_regwrite = ex_memread | 1'($urandom);
      mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
      ex_muldiv = (md_left > 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
      ex_redirect = (md_left == 0) && ($urandom_range(0, 7) == 0);
      dmem_ready = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 127) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
